// File: rtl/wb_slave_mem_if.sv
// Wishbone B3 bus bundle between the MAC DMA master and wb_slave_mem.
// Names take the master's view: *_o leave the master, *_i return to it.
//   master modport: drives adr/sel/we/dat_o/cyc/stb/cti/bte
//   slave modport : drives dat_i/ack/err
interface wb_slave_mem_if;
    logic [31:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;

    modport master (
        output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        output m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o,
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
        output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
    );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone B3 slave memory behind the Ethernet MAC DMA master port.
// Ports: wb_clk (clock), wb_rst (async active-high reset),
//   bus (wb_slave_mem_if.slave): adr/sel/we/dat_o/cyc/stb/cti/bte in,
//   dat_i/ack/err out. Supports wait states, registered-feedback
//   bursts (constant, linear, wrap-4/8/16) and an error window.
module wb_slave_mem #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter bit          BURST_EN    = 1'b1
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    wb_slave_mem_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_BURST
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] bst_q, bst_d;
    logic [2:0]  cti_q, cti_d;
    logic [1:0]  bte_q, bte_d;
    logic        ack_q, err_q;
    logic [31:0] dat_q;

    logic [31:0] mem [2**AW];

    logic          req;
    logic          fire;
    logic          hit;
    logic          last;
    logic          bmode;
    logic [31:0]   beat_adr;
    logic [AW-1:0] idx;
    logic          unused_adr;

    // Next burst address. Wrap modes only touch the low index bits,
    // so a wrap burst never leaves its aligned block.
    function automatic logic [31:0] step(
        input logic [31:0] a,
        input logic [2:0]  c,
        input logic [1:0]  t
    );
        logic [31:0] n;
        n = a;
        if (c == 3'b010) begin
            unique case (t)
                2'b00:   n = a + 32'd4;
                2'b01:   n[3:2] = a[3:2] + 2'd1;
                2'b10:   n[4:2] = a[4:2] + 3'd1;
                default: n[5:2] = a[5:2] + 4'd1;
            endcase
        end
        return n;
    endfunction

    assign req   = bus.m_wb_cyc_o & bus.m_wb_stb_o;
    assign last  = (bus.m_wb_cti_o == 3'b111);
    assign bmode = BURST_EN &&
                   (cti_q == 3'b001 || cti_q == 3'b010);

    // First beat comes straight off the bus; later beats use the
    // internally tracked address, never adr.
    assign beat_adr = (state_q == S_IDLE) ? bus.m_wb_adr_o : bst_q;
    assign hit      = (beat_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign idx      = beat_adr[AW+1:2];
    assign unused_adr = ^beat_adr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bst_d   = bst_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // ack/err still high means the previous beat is
                // being terminated; do not resample that request.
                if (req && !ack_q && !err_q) begin
                    cti_d = bus.m_wb_cti_o;
                    bte_d = bus.m_wb_bte_o;
                    cnt_d = 4'(WAIT_STATES);
                    bst_d = bus.m_wb_adr_o;
                    if (WAIT_STATES == 0) begin
                        fire    = 1'b1;
                        state_d = S_BEAT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.m_wb_cyc_o) begin
                    state_d = S_IDLE;
                end else if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (bus.m_wb_stb_o) begin
                    fire    = 1'b1;
                    state_d = S_BEAT;
                end
            end
            S_BEAT: begin
                if (!bus.m_wb_cyc_o || !bmode || err_q) begin
                    state_d = S_IDLE;
                end else begin
                    // Burst continues with no gap after the first ack.
                    state_d = S_BURST;
                    fire    = bus.m_wb_stb_o;
                end
            end
            S_BURST: begin
                if (!bus.m_wb_cyc_o) begin
                    state_d = S_IDLE;
                end else begin
                    fire = bus.m_wb_stb_o;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fire) begin
            bst_d = step(beat_adr, cti_d, bte_d);
            if (state_q == S_BEAT || state_q == S_BURST) begin
                if (!hit || last) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bst_q   <= '0;
            cti_q   <= '0;
            bte_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bst_q   <= bst_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            ack_q   <= fire & hit;
            err_q   <= fire & ~hit;
            if (fire) begin
                if (!hit) begin
                    dat_q <= '0;
                end else if (!bus.m_wb_we_o) begin
                    dat_q <= mem[idx];
                end
            end
        end
    end

    // Contents survive reset; a beat caught by reset never commits.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst && fire && hit && bus.m_wb_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.m_wb_sel_o[b]) begin
                    mem[idx][8*b +: 8] <= bus.m_wb_dat_o[8*b +: 8];
                end
            end
        end
    end

    assign bus.m_wb_dat_i = dat_q;
    assign bus.m_wb_ack_i = ack_q;
    assign bus.m_wb_err_i = err_q;

endmodule
